// File: rtl/gameover_pkg.sv
// Shared types, FSM encodings and the brightness-scaling helper for the game-over overlay.
// Pure combinational helpers only; no state lives here.
package gameover_pkg;
    localparam int LEVEL_W = 5;
    localparam int COLOR_W = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t FADE_IN  = 2'd1;
    localparam state_t HOLD     = 2'd2;
    localparam state_t FADE_OUT = 2'd3;

    // (c * level) >> 4: level 16 passes the colour through, level 0 is black.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                      input logic [LEVEL_W-1:0] level);
        logic [COLOR_W+LEVEL_W-1:0] prod;
        prod = {{LEVEL_W{1'b0}}, c} * {{COLOR_W{1'b0}}, level};
        return COLOR_W'(prod >> 4);
    endfunction
endpackage

// File: rtl/gameover_fade_scaler.sv
// Combinational 3-channel brightness scaler; zero latency, the controller registers the result.
module gameover_fade_scaler
    import gameover_pkg::*;
(
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    input  logic [LEVEL_W-1:0] level,
    output logic [COLOR_W-1:0] scaled_red,
    output logic [COLOR_W-1:0] scaled_green,
    output logic [COLOR_W-1:0] scaled_blue
);
    assign scaled_red   = scale_chan(red,   level);
    assign scaled_green = scale_chan(green, level);
    assign scaled_blue  = scale_chan(blue,  level);
endmodule

// File: rtl/gameover_fade_ctrl.sv
// Game-over overlay sequencer: fade in, hold, fade out on restart. pal_index is combinational,
// ovl_* one cycle after rom_index/in_region. GAMEOVER_BLINK_EN enables masked palette blinking in HOLD.
module gameover_fade_ctrl
    import gameover_pkg::*;
#(
    parameter int          FRAMES_PER_STEP = 4,
    parameter int          MIN_HOLD_FRAMES = 60,
    parameter int          BLINK_FRAMES    = 30,
    parameter logic [15:0] BLINK_MASK      = 16'h5514
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       game_over,
    input  logic       restart_req,
    input  logic       vsync_tick,
    input  logic [3:0] rom_index,
    input  logic       in_region,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] ovl_red,
    output logic [3:0] ovl_green,
    output logic [3:0] ovl_blue,
    output logic       ovl_valid,
    output logic       overlay_active,
    output logic       restart_ack
);
    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HC_W = $clog2(MIN_HOLD_FRAMES + 1);

    state_t              state;
    logic [LEVEL_W-1:0]  level;
    logic [FC_W-1:0]     frame_cnt;
    logic [HC_W-1:0]     hold_cnt;
    logic                go_prev;
    logic                frame_last;
    logic                step;
    logic                hold_done;
    logic [COLOR_W-1:0]  sc_red, sc_green, sc_blue;

    assign frame_last     = (frame_cnt == FC_W'(FRAMES_PER_STEP - 1));
    assign step           = vsync_tick && frame_last;
    assign hold_done      = (hold_cnt == HC_W'(MIN_HOLD_FRAMES));
    assign overlay_active = (state != IDLE);

    gameover_fade_scaler u_scaler (
        .red          (pal_red),
        .green        (pal_green),
        .blue         (pal_blue),
        .level        (level),
        .scaled_red   (sc_red),
        .scaled_green (sc_green),
        .scaled_blue  (sc_blue)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            level       <= '0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            // Treat game_over as already high so a level held across reset cannot start the overlay.
            go_prev     <= 1'b1;
            ovl_red     <= '0;
            ovl_green   <= '0;
            ovl_blue    <= '0;
            ovl_valid   <= 1'b0;
            restart_ack <= 1'b0;
        end else begin
            go_prev     <= game_over;
            restart_ack <= 1'b0;
            ovl_red     <= sc_red;
            ovl_green   <= sc_green;
            ovl_blue    <= sc_blue;
            ovl_valid   <= in_region && (state != IDLE);
            if (vsync_tick)
                frame_cnt <= frame_last ? '0 : frame_cnt + FC_W'(1);
            case (state)
                IDLE: begin
                    if (game_over && !go_prev) begin
                        state     <= FADE_IN;
                        level     <= '0;
                        frame_cnt <= '0;
                    end
                end
                FADE_IN: begin
                    if (step) begin
                        level <= level + 5'd1;
                        if (level == LEVEL_MAX - 5'd1) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (vsync_tick && !hold_done)
                        hold_cnt <= hold_cnt + HC_W'(1);
                    if (restart_req && hold_done) begin
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                    end
                end
                FADE_OUT: begin
                    if (step) begin
                        level <= level - 5'd1;
                        if (level == 5'd1) begin
                            state       <= IDLE;
                            restart_ack <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GAMEOVER_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BC_W-1:0] blink_cnt;
    logic            blink_phase;

    always_ff @(posedge Clk) begin
        if (!Reset_n || state != HOLD) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (vsync_tick) begin
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BC_W'(1);
            end
        end
    end

    assign pal_index = (blink_phase && BLINK_MASK[rom_index]) ? 4'd0 : rom_index;
`else
    assign pal_index = rom_index;
`endif
endmodule

// File: tb/tb_gameover_fade_ctrl.sv
// Directed bench for gameover_fade_ctrl with one-frame steps and a 60-frame hold.
module tb_gameover_fade_ctrl;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       game_over, restart_req, vsync_tick, in_region;
    logic [3:0] rom_index, pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic [3:0] ovl_red, ovl_green, ovl_blue;
    logic       ovl_valid, overlay_active, restart_ack;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    gameover_fade_ctrl #(
        .FRAMES_PER_STEP (1),
        .MIN_HOLD_FRAMES (60),
        .BLINK_FRAMES    (2),
        .BLINK_MASK      (16'h5514)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .game_over      (game_over),
        .restart_req    (restart_req),
        .vsync_tick     (vsync_tick),
        .rom_index      (rom_index),
        .in_region      (in_region),
        .pal_index      (pal_index),
        .pal_red        (pal_red),
        .pal_green      (pal_green),
        .pal_blue       (pal_blue),
        .ovl_red        (ovl_red),
        .ovl_green      (ovl_green),
        .ovl_blue       (ovl_blue),
        .ovl_valid      (ovl_valid),
        .overlay_active (overlay_active),
        .restart_ack    (restart_ack)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (restart_ack === 1'b1)
            ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One frame tick: the step lands on the first edge, ovl_* shows the new level after the second.
    task automatic pulse_vsync();
        vsync_tick = 1'b1;
        cyc(1);
        vsync_tick = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            pulse_vsync();
    endtask

    initial begin
        Reset_n     = 1'b0;
        game_over   = 1'b1;
        restart_req = 1'b0;
        vsync_tick  = 1'b0;
        in_region   = 1'b1;
        rom_index   = 4'd3;
        pal_red     = 4'hF;
        pal_green   = 4'hF;
        pal_blue    = 4'hF;

        // Reset with game_over already high
        cyc(4);
        check_val("rst_active", overlay_active, 0);
        check_val("rst_valid",  ovl_valid, 0);
        check_val("rst_red",    ovl_red, 0);
        check_val("rst_green",  ovl_green, 0);
        check_val("rst_blue",   ovl_blue, 0);
        check_val("rst_ack",    restart_ack, 0);
        check_val("rst_palidx", pal_index, 3);
        Reset_n = 1'b1;
        cyc(2);
        ticks(3);
        check_val("no_retrigger_active", overlay_active, 0);
        check_val("no_retrigger_valid",  ovl_valid, 0);

        // Fade in from a fresh game_over edge
        game_over = 1'b0;
        cyc(1);
        game_over = 1'b1;
        cyc(1);
        check_val("fadein_active", overlay_active, 1);
        cyc(1);
        check_val("fadein_l0", ovl_red, 0);
        check_val("fadein_valid", ovl_valid, 1);
        for (int i = 1; i <= 16; i++) begin
            pulse_vsync();
            check_val($sformatf("fadein_l%0d", i), ovl_red, (15 * i) >> 4);
            if (i == 5) begin
                restart_req = 1'b1;
                cyc(1);
                restart_req = 1'b0;
                cyc(1);
            end
            if (i == 8) begin
                pal_red   = 4'h6;
                pal_green = 4'hD;
                pal_blue  = 4'hF;
                in_region = 1'b0;
                cyc(1);
                check_val("l8_red",   ovl_red, 3);
                check_val("l8_green", ovl_green, 6);
                check_val("l8_blue",  ovl_blue, 7);
                check_val("l8_valid_off", ovl_valid, 0);
                pal_red   = 4'hF;
                pal_green = 4'hF;
                pal_blue  = 4'hF;
                in_region = 1'b1;
                cyc(1);
                check_val("l8_valid_on", ovl_valid, 1);
            end
        end
        check_val("hold_active", overlay_active, 1);

        // HOLD: blink pattern over the first frames, then the early restart
        rom_index = 4'd2;
        for (int n = 1; n <= 59; n++) begin
            pulse_vsync();
            if (n <= 8) begin
`ifdef GAMEOVER_BLINK_EN
                check_val($sformatf("blink_idx2_t%0d", n), pal_index, ((n / 2) % 2) ? 0 : 2);
`else
                check_val($sformatf("idx2_t%0d", n), pal_index, 2);
`endif
            end
        end
        rom_index = 4'd1;
        #1;
        check_val("idx1_unmasked", pal_index, 1);
        rom_index = 4'd2;
        #1;
`ifdef GAMEOVER_BLINK_EN
        check_val("blink_idx2_t59", pal_index, 0);
`else
        check_val("idx2_t59", pal_index, 2);
`endif
        rom_index = 4'd3;

        restart_req = 1'b1;
        cyc(1);
        restart_req = 1'b0;
        cyc(1);
        ticks(3);
        check_val("early_restart_dropped", ovl_red, 15);
        check_val("early_restart_active", overlay_active, 1);

        // Restart with a simultaneous frame tick after the hold counter has saturated
        vsync_tick  = 1'b1;
        restart_req = 1'b1;
        cyc(1);
        vsync_tick  = 1'b0;
        restart_req = 1'b0;
        cyc(1);
        check_val("fadeout_start_red", ovl_red, 15);
        for (int k = 15; k >= 0; k--) begin
            if (k == 0)
                check_val("ack_not_early", ack_cnt, 0);
            pulse_vsync();
            check_val($sformatf("fadeout_l%0d", k), ovl_red, (15 * k) >> 4);
        end
        cyc(2);
        check_val("ack_once", ack_cnt, 1);
        check_val("fadeout_idle", overlay_active, 0);
        check_val("fadeout_valid", ovl_valid, 0);

        // Second overlay, then reset in the middle of the fade out
        game_over = 1'b0;
        cyc(1);
        game_over = 1'b1;
        cyc(1);
        check_val("second_active", overlay_active, 1);
        ticks(16);
        ticks(60);
        restart_req = 1'b1;
        cyc(1);
        restart_req = 1'b0;
        cyc(1);
        ticks(9);
        check_val("mid_fadeout_l7", ovl_red, 6);
        Reset_n = 1'b0;
        cyc(1);
        Reset_n = 1'b1;
        check_val("midrst_active", overlay_active, 0);
        check_val("midrst_red", ovl_red, 0);
        check_val("midrst_valid", ovl_valid, 0);
        ticks(20);
        check_val("midrst_no_ack", ack_cnt, 1);
        check_val("midrst_still_idle", overlay_active, 0);

        // Level restarts from black on the next overlay
        game_over = 1'b0;
        cyc(1);
        game_over = 1'b1;
        cyc(2);
        check_val("third_active", overlay_active, 1);
        check_val("third_l0", ovl_red, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
